// File: rtl/jstk_dir_decoder.sv
// jstk_dir_decoder: PmodJSTK packet -> debounced X/Y direction codes plus raw buttons.
// Latency 2 cycles (sample_valid -> dir_valid), accepts a sample every cycle, no backpressure.
// Build option JSTK_HYST_EN: a committed high/low code is held with a HYST-wide margin.
module jstk_dir_decoder #(
    parameter int AXIS_W     = 10,
    parameter int LOW_TH     = 400,
    parameter int HIGH_TH    = 600,
    parameter int HYST       = 16,
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [39:0] jstkData,
    output logic [1:0]  dir_x,
    output logic [1:0]  dir_y,
    output logic [2:0]  btn,
    output logic        dir_valid,
    output logic        dir_changed
);

    localparam int CW = $clog2(STABLE_CNT) + 1;

    localparam logic [1:0] DIR_C = 2'd0;
    localparam logic [1:0] DIR_H = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;

    localparam logic [AXIS_W-1:0] LOW_W   = AXIS_W'(LOW_TH);
    localparam logic [AXIS_W-1:0] HIGH_W  = AXIS_W'(HIGH_TH);
    localparam logic [AXIS_W-1:0] LO_HOLD = AXIS_W'(LOW_TH + HYST);
    localparam logic [AXIS_W-1:0] HI_HOLD = AXIS_W'(HIGH_TH - HYST);
    localparam logic [CW-1:0]     STABLE_W = CW'(STABLE_CNT);

`ifdef JSTK_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Stage 1: captured packet fields
    logic [AXIS_W-1:0] pos_q [2];
    logic [2:0]        btn_q;
    logic              s1_vld;

    // Stage 2 state, index 0 = X, 1 = Y
    logic [1:0]    comm_q [2];
    logic [1:0]    prev_q [2];
    logic [CW-1:0] cnt_q  [2];

    logic [1:0]    cand   [2];
    logic [1:0]    comm_d [2];
    logic [CW-1:0] cnt_d  [2];
    logic [CW-1:0] cnt_inc[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q[0] <= '0;
            pos_q[1] <= '0;
            btn_q    <= '0;
            s1_vld   <= 1'b0;
        end else begin
            s1_vld <= sample_valid;
            if (sample_valid) begin
                pos_q[0] <= AXIS_W'({jstkData[9:8], jstkData[23:16]});
                pos_q[1] <= AXIS_W'({jstkData[25:24], jstkData[39:32]});
                btn_q    <= jstkData[2:0];
            end
        end
    end

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            if (pos_q[a] < LOW_W)
                cand[a] = DIR_L;
            else if (pos_q[a] > HIGH_W)
                cand[a] = DIR_H;
            else
                cand[a] = DIR_C;
            // A committed extreme survives until the position backs off past the margin
            if (HYST_ON && comm_q[a] == DIR_H && pos_q[a] > HI_HOLD)
                cand[a] = DIR_H;
            if (HYST_ON && comm_q[a] == DIR_L && pos_q[a] < LO_HOLD)
                cand[a] = DIR_L;

            comm_d[a]  = comm_q[a];
            cnt_d[a]   = cnt_q[a];
            cnt_inc[a] = '0;
            if (cand[a] == comm_q[a]) begin
                cnt_d[a] = '0;
            end else begin
                if (cand[a] == prev_q[a])
                    cnt_inc[a] = (cnt_q[a] == '1) ? cnt_q[a] : cnt_q[a] + 1'b1;
                else
                    cnt_inc[a] = CW'(1);
                if (cnt_inc[a] >= STABLE_W) begin
                    comm_d[a] = cand[a];
                    cnt_d[a]  = '0;
                end else begin
                    cnt_d[a] = cnt_inc[a];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 2; a++) begin
                comm_q[a] <= DIR_C;
                prev_q[a] <= DIR_C;
                cnt_q[a]  <= '0;
            end
            btn         <= '0;
            dir_valid   <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            dir_valid   <= s1_vld;
            dir_changed <= 1'b0;
            if (s1_vld) begin
                for (int a = 0; a < 2; a++) begin
                    comm_q[a] <= comm_d[a];
                    prev_q[a] <= cand[a];
                    cnt_q[a]  <= cnt_d[a];
                end
                btn         <= btn_q;
                dir_changed <= (comm_d[0] != comm_q[0]) || (comm_d[1] != comm_q[1]);
            end
        end
    end

    assign dir_x = comm_q[0];
    assign dir_y = comm_q[1];

endmodule

// File: tb/tb_jstk_dir_decoder.sv
// Bench for jstk_dir_decoder: two instances (STABLE_CNT 1 and 4) share one stimulus stream
// and are compared every cycle against a run-length reference model.
module tb_jstk_dir_decoder;

    localparam int LOW_TH  = 400;
    localparam int HIGH_TH = 600;
    localparam int HYST    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [39:0] jstkData = '0;

    logic [1:0] dx [2];
    logic [1:0] dy [2];
    logic [2:0] bt [2];
    logic       dv [2];
    logic       dc [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jstk_dir_decoder #(.AXIS_W(10), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HYST(HYST), .STABLE_CNT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .jstkData(jstkData),
        .dir_x(dx[0]), .dir_y(dy[0]), .btn(bt[0]), .dir_valid(dv[0]), .dir_changed(dc[0]));

    jstk_dir_decoder #(.AXIS_W(10), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HYST(HYST), .STABLE_CNT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .jstkData(jstkData),
        .dir_x(dx[1]), .dir_y(dy[1]), .btn(bt[1]), .dir_valid(dv[1]), .dir_changed(dc[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a direction commits once the last N classifications agree and differ from it
    typedef struct {
        int due;
        int dx;
        int dy;
        int b;
        int ch;
    } exp_t;

    int   comm [2][2];
    int   rv   [2][2];
    int   rl   [2][2];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t cur0, cur1;

    function automatic int ns(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int cls(input int p, input int c);
`ifdef JSTK_HYST_EN
        if (c == 1 && p > HIGH_TH - HYST) return 1;
        if (c == 2 && p < LOW_TH + HYST) return 2;
`else
        if (c < 0) return 0;
`endif
        if (p < LOW_TH) return 2;
        if (p > HIGH_TH) return 1;
        return 0;
    endfunction

    task automatic step(input int i, input int a, input int p);
        int c;
        c = cls(p, comm[i][a]);
        if (c == rv[i][a]) rl[i][a]++;
        else begin
            rv[i][a] = c;
            rl[i][a] = 1;
        end
        if (c != comm[i][a] && rl[i][a] >= ns(i)) comm[i][a] = c;
    endtask

    task automatic model_accept(input int x, input int y, input int b);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            int ox, oy;
            ox = comm[i][0];
            oy = comm[i][1];
            step(i, 0, x);
            step(i, 1, y);
            e.due = cyc + 2;
            e.dx  = comm[i][0];
            e.dy  = comm[i][1];
            e.b   = b;
            e.ch  = (ox != comm[i][0] || oy != comm[i][1]) ? 1 : 0;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 2; a++) begin
                comm[i][a] = 0;
                rv[i][a]   = 0;
                rl[i][a]   = 0;
            end
        q0.delete();
        q1.delete();
        cur0 = '{default: 0};
        cur1 = '{default: 0};
    endtask

    task automatic check_inst(input string s, input logic v, input logic c, input logic [1:0] x,
                              input logic [1:0] y, input logic [2:0] b, input bit due, input exp_t e);
        chk({s, "_valid"}, 32'(v), 32'(due));
        chk({s, "_changed"}, 32'(c), due ? e.ch : 0);
        chk({s, "_dir_x"}, 32'(x), e.dx);
        chk({s, "_dir_y"}, 32'(y), e.dy);
        chk({s, "_btn"}, 32'(b), e.b);
    endtask

    always @(negedge clk) begin
        bit d0, d1;
        if (chk_on) begin
            d0 = (q0.size() > 0) && (q0[0].due == cyc);
            d1 = (q1.size() > 0) && (q1[0].due == cyc);
            if (d0) cur0 = q0.pop_front();
            if (d1) cur1 = q1.pop_front();
            check_inst("n1", dv[0], dc[0], dx[0], dy[0], bt[0], d0, cur0);
            check_inst("n4", dv[1], dc[1], dx[1], dy[1], bt[1], d1, cur1);
        end
    end

    task automatic drive(input bit v, input int x, input int y, input int b);
        logic [39:0] d;
        @(negedge clk);
        #2;
        d[31:0]  = $urandom;
        d[39:32] = 8'($urandom);
        d[9:8]   = 2'(x >> 8);
        d[23:16] = 8'(x);
        d[25:24] = 2'(y >> 8);
        d[39:32] = 8'(y);
        d[2:0]   = 3'(b);
        jstkData     = d;
        sample_valid = v;
        if (v) model_accept(x, y, b);
    endtask

    task automatic samp(input int x, input int y, input int b);
        drive(1'b1, x, y, b);
    endtask

    // Let the last driven sample reach the outputs, then sample them
    task automatic last_out();
        drive(1'b0, 512, 512, 0);
        @(negedge clk);
        #1;
    endtask

    function automatic int rpos();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 1023));
            1:       return int'($urandom_range(380, 420));
            2:       return int'($urandom_range(580, 620));
            default: return (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : int'($urandom_range(800, 1023)));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_dir_x", 32'(dx[i]), 0);
            chk("rst_dir_y", 32'(dy[i]), 0);
            chk("rst_btn", 32'(bt[i]), 0);
            chk("rst_valid", 32'(dv[i]), 0);
            chk("rst_changed", 32'(dc[i]), 0);
        end
        #1 rst_n = 1'b1;

        // Centered sample, buttons pass through
        samp(512, 512, 5);
        last_out();
        chk("first_valid", 32'(dv[0]), 1);
        chk("first_dir", 32'({dx[0], dy[0]}), 0);
        chk("first_btn", 32'(bt[0]), 5);
        chk("first_changed", 32'(dc[0]), 0);

        // Debounce on the 4-sample instance
        repeat (4) samp(300, 512, 0);
        last_out();
        chk("deb4_dir_x", 32'(dx[1]), 2);
        chk("deb4_changed", 32'(dc[1]), 1);
        repeat (4) samp(512, 512, 0);
        repeat (3) samp(300, 512, 0);
        samp(512, 512, 0);
        last_out();
        chk("deb3_dir_x", 32'(dx[1]), 0);

        // Threshold boundaries on the immediate-commit instance
        samp(400, 512, 0); last_out(); chk("x400", 32'(dx[0]), 0);
        samp(399, 512, 0); last_out(); chk("x399", 32'(dx[0]), 2);
        samp(600, 512, 0); last_out(); chk("x600", 32'(dx[0]), 0);
        samp(601, 512, 0); last_out(); chk("x601", 32'(dx[0]), 1);

        // Hold margins around committed extremes
`ifdef JSTK_HYST_EN
        samp(590, 512, 0); last_out(); chk("hold_hi590", 32'(dx[0]), 1);
`else
        samp(590, 512, 0); last_out(); chk("hold_hi590", 32'(dx[0]), 0);
`endif
        samp(601, 512, 0);
        samp(584, 512, 0); last_out(); chk("hold_hi584", 32'(dx[0]), 0);
        samp(399, 512, 0);
`ifdef JSTK_HYST_EN
        samp(415, 512, 0); last_out(); chk("hold_lo415", 32'(dx[0]), 2);
`else
        samp(415, 512, 0); last_out(); chk("hold_lo415", 32'(dx[0]), 0);
`endif
        samp(399, 512, 0);
        samp(416, 512, 0); last_out(); chk("hold_lo416", 32'(dx[0]), 0);

        // Both axes commit together
        repeat (4) samp(700, 100, 2);
        last_out();
        chk("both_dir_x", 32'(dx[1]), 1);
        chk("both_dir_y", 32'(dy[1]), 2);
        chk("both_changed", 32'(dc[1]), 1);

        // Reset with a sample in flight
        samp(700, 512, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) drive(1'b0, 700, 512, 0);
        @(negedge clk);
        #1;
        chk("post_rst_dir_x", 32'(dx[0]), 0);
        chk("post_rst_valid", 32'(dv[0]), 0);

        // Random runs of repeated positions, the per-cycle checker compares against the model
        for (int g = 0; g < 150; g++) begin
            int x, y, b, reps;
            x = rpos();
            y = rpos();
            b = int'($urandom_range(0, 7));
            reps = int'($urandom_range(1, 6));
            for (int r = 0; r < reps; r++)
                drive(($urandom_range(0, 9) < 8), x, y, b);
        end
        repeat (4) drive(1'b0, 512, 512, 0);
        @(negedge clk);
        #1;
        chk("drain_q", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jstk_dir_decoder.md
# jstk_dir_decoder

Two-axis direction decoder for PmodJSTK packets: extracts X and Y positions and the three button bits from the 40-bit `jstkData` word, classifies each axis into low/center/high against parametrised thresholds, and commits a new direction only after it has been stable for a programmable number of samples. It sits between the joystick SPI interface and the car-control logic. It generalises the single-axis, unfiltered X-only formatter to both axes, adding a sample strobe, debounce and optional hysteresis.

## Interface
- `AXIS_W`, 10, position width per axis.
- `LOW_TH`, 400, an axis is low when position < `LOW_TH`.
- `HIGH_TH`, 600, an axis is high when position > `HIGH_TH`.
- `HYST`, 16, hysteresis margin, used only with `JSTK_HYST_EN`.
- `STABLE_CNT`, 4, consecutive identical samples needed to commit a change (≥1).
- `clk` in 1: system clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; `jstkData` holds a fresh packet.
- `jstkData` in 40: raw packet. X = {`jstkData[9:8]`, `jstkData[23:16]`}, Y = {`jstkData[25:24]`, `jstkData[39:32]`}, buttons = `jstkData[2:0]`.
- `dir_x` out 2: committed X direction (0 center, 1 high, 2 low; 3 never driven).
- `dir_y` out 2: committed Y direction, same encoding.
- `btn` out 3: buttons registered from the accepted packet.
- `dir_valid` out 1: one-cycle pulse when a sample's results are on the outputs.
- `dir_changed` out 1: one-cycle pulse, coincident with `dir_valid`, when `dir_x` or `dir_y` changed on that update.

## Operation
- Stage 1: on `sample_valid`, X, Y and buttons are captured into registers. No capture when `sample_valid` is low.
- Stage 2: each axis is classified into a candidate code. Comparisons are unsigned at `AXIS_W` bits and strict: a position equal to `LOW_TH` or `HIGH_TH` is center.
- Each axis has a debounce counter (width clog2(`STABLE_CNT`)+1, saturating) and a stored previous candidate.
  - Candidate == committed: the counter clears.
  - Candidate ≠ committed and equal to the previous candidate: the counter increments.
  - Candidate ≠ committed and different from the previous candidate: the counter loads 1.
  - When the counter would reach `STABLE_CNT`, the committed code takes the candidate and the counter clears.
  - With `STABLE_CNT`=1, every candidate commits immediately.
- A direct low→high (or high→low) jump is treated like any other change; it does not pass through center.
- Both axes are independent; both may commit on the same update.
- `btn` updates on every accepted sample with no debounce.
- Required parameter relation: `LOW_TH` + `HYST` ≤ `HIGH_TH` − `HYST`.

## Timing
- Latency: `sample_valid` at cycle t → `dir_x`, `dir_y`, `btn` updated and `dir_valid` high at t+2.
- `sample_valid` may be asserted every cycle; the block has full throughput and no backpressure.
- `dir_valid` and `dir_changed` are high only for the single t+2 cycle belonging to each accepted sample.
- Outputs hold their values between updates.
- Reset values (asynchronous, on `rst_n` low): `dir_x`=0, `dir_y`=0, `btn`=0, `dir_valid`=0, `dir_changed`=0. Counters, previous candidates and pipeline registers also clear to 0.
- Reset mid-operation: a sample in flight is discarded. The first `dir_valid` after release belongs to the first `sample_valid` accepted after release.

## Configuration
- `JSTK_HYST_EN` defined: classification depends on the committed state.
  - Committed high: the candidate stays high while position > `HIGH_TH` − `HYST`.
  - Committed low: the candidate stays low while position < `LOW_TH` + `HYST`.
  - Otherwise, plain thresholds apply.
- `JSTK_HYST_EN` undefined: plain strict thresholds only; `HYST` is ignored.

## Test plan
- Reset, then a single sample with X=512, Y=512, btn=3'b101, `STABLE_CNT`=1 → at t+2: `dir_valid`=1, dirs 0/0, `btn`=5, `dir_changed`=0.
- `STABLE_CNT`=4, four back-to-back samples with X=300 → `dir_x` becomes 2 and `dir_changed` pulses only on the 4th `dir_valid`. Three samples of X=300 followed by X=512 → `dir_x` stays 0.
- Boundary samples: X=400 → 0; X=399 → 2; X=600 → 0; X=601 → 1 (hysteresis off, `STABLE_CNT`=1).
- `JSTK_HYST_EN`, HYST=16, committed high: X=590 → stays 1; X=584 → 0. Committed low: X=415 → stays 2; X=416 → 0.
- Simultaneous commit: X=700, Y=100 for `STABLE_CNT` samples → `dir_x`=1 and `dir_y`=2 on the same cycle, with one `dir_changed` pulse.
- Assert `rst_n` low one cycle after `sample_valid` with X=700 → no `dir_valid`; all outputs stay 0 after release.
